// File: rtl/soc_reset_sequencer.sv
// ----------------------------------------------------------------------------
// soc_reset_sequencer
// Purpose: sequences the SoC reset release. Peripherals are released first
// and the CPU core a fixed delay later. A pushbutton or a watchdog pulse
// restarts the sequence. Each restart is counted, and its cause is recorded.
//
// Optional build macro: RST_DEBOUNCE_EN. When it is defined, a press must
// stay low for DEBOUNCE_CYCLES synchronized cycles before it counts. When it
// is not defined, any synchronized-low cycle counts as a press.
//
// Ports:
//   clock         single clock; all state changes on its rising edge
//   resetn        synchronous active-low reset
//   btn_n         asynchronous reset button, low = pressed
//   wdt_expire    one-cycle synchronous watchdog/software reset request
//   periph_rst_n  active-low reset to bus/UART/GPIO (flop output)
//   cpu_rst_n     active-low reset to the CPU core (flop output)
//   seq_busy      high in every state except RUN (flop output)
//   rst_cause     last reset cause: 00 power-on, 01 button, 10 watchdog
//   rst_count     button + watchdog resets since resetn, saturating at 255
// ----------------------------------------------------------------------------
module soc_reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PERIPH_HOLD     = 8,
    parameter int unsigned CPU_DELAY       = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       btn_n,
    input  logic       wdt_expire,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic       seq_busy,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    localparam int unsigned HOLD_W = (PERIPH_HOLD > 1) ? $clog2(PERIPH_HOLD) : 1;
    localparam int unsigned DLY_W  = (CPU_DELAY > 1) ? $clog2(CPU_DELAY) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PERIPH_HOLD - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(CPU_DELAY - 1);

    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_PERIPH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    logic              sync1_q;
    logic              sync2_q;
    logic              btn_sync;
    logic              press_c;
    logic              event_c;

    logic [1:0]        state_q,  state_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [DLY_W-1:0]  dly_q,    dly_d;
    logic [1:0]        cause_q,  cause_d;
    logic [7:0]        count_q,  count_d;
    logic              periph_q, periph_d;
    logic              cpu_q,    cpu_d;
    logic              busy_q,   busy_d;

    // Two-flop synchronizer for the asynchronous button; idles released (1).
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign btn_sync = sync2_q;

`ifdef RST_DEBOUNCE_EN
    localparam int unsigned DEB_NEED = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DEB_W    = (DEB_NEED > 5) ? DEB_NEED : 5;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_SAT  = DEB_W'(DEBOUNCE_CYCLES);

    logic [DEB_W-1:0] deb_q, deb_d;

    // Debounce counter: counts low cycles and parks one past the qualifying
    // value, so a continuous hold yields a single press.
    always_comb begin
        deb_d = deb_q;
        if (btn_sync) begin
            deb_d = '0;
        end else if (deb_q != DEB_SAT) begin
            deb_d = deb_q + DEB_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb_d;
        end
    end

    assign press_c = ~btn_sync && (deb_q == DEB_LAST);
`else
    assign press_c = ~btn_sync;
`endif

    // Next-state, counter and output decode. Outputs are registered from the
    // next state so they change on the same edge as the state itself.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dly_d   = dly_q;
        cause_d = cause_q;
        count_d = count_q;
        event_c = press_c | wdt_expire;

        if ((state_q != ST_HOLD) && event_c) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            dly_d   = '0;
            cause_d = press_c ? CAUSE_BTN : CAUSE_WDT;
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    dly_d = '0;
                    if (hold_q == HOLD_LAST) begin
                        // A held button keeps both resets asserted.
                        if (btn_sync) begin
                            state_d = ST_PERIPH;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_PERIPH: begin
                    if (dly_q == DLY_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        dly_d = dly_q + DLY_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    dly_d   = '0;
                end
            endcase
        end

        periph_d = (state_d != ST_HOLD);
        cpu_d    = (state_d == ST_RUN);
        busy_d   = (state_d != ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_HOLD;
            hold_q   <= '0;
            dly_q    <= '0;
            cause_q  <= 2'b00;
            count_q  <= 8'd0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            dly_q    <= dly_d;
            cause_q  <= cause_d;
            count_q  <= count_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            busy_q   <= busy_d;
        end
    end

    assign periph_rst_n = periph_q;
    assign cpu_rst_n    = cpu_q;
    assign seq_busy     = busy_q;
    assign rst_cause    = cause_q;
    assign rst_count    = count_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_soc_reset_sequencer
// Purpose: directed and random stimulus for soc_reset_sequencer. Every cycle
// is compared against a behavioural model that tracks elapsed times
// (cycles in hold, cycles since release), a two-entry synchronizer history
// and the length of the current low run of the button.
// Honours RST_DEBOUNCE_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_soc_reset_sequencer;

    localparam int DEB = 16;
    localparam int PH  = 8;
    localparam int CD  = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic       btn_n;
    logic       wdt_expire;
    logic       periph_rst_n;
    logic       cpu_rst_n;
    logic       seq_busy;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    bit m_in_hold;
    int m_elapsed;
    int m_since_rel;
    int m_cause;
    int m_count;
    bit m_s0, m_s1;
    int m_low_run;

    soc_reset_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .PERIPH_HOLD    (PH),
        .CPU_DELAY      (CD)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .btn_n       (btn_n),
        .wdt_expire  (wdt_expire),
        .periph_rst_n(periph_rst_n),
        .cpu_rst_n   (cpu_rst_n),
        .seq_busy    (seq_busy),
        .rst_cause   (rst_cause),
        .rst_count   (rst_count)
    );

    always #5 clock = ~clock;

    // Advance the model by one rising edge with the inputs sampled there.
    task automatic model_step(input bit b, input bit w, input bit r);
        bit press;
        if (!r) begin
            m_in_hold   = 1'b1;
            m_elapsed   = 0;
            m_since_rel = 0;
            m_cause     = 0;
            m_count     = 0;
            m_s0        = 1'b1;
            m_s1        = 1'b1;
            m_low_run   = 0;
        end else begin
`ifdef RST_DEBOUNCE_EN
            press     = !m_s1 && (m_low_run + 1 == DEB);
            m_low_run = m_s1 ? 0 : m_low_run + 1;
`else
            press = !m_s1;
`endif
            if (m_in_hold) begin
                if (m_elapsed >= PH - 1 && m_s1) begin
                    m_in_hold   = 1'b0;
                    m_since_rel = 0;
                end else begin
                    m_elapsed++;
                end
            end else if (press || w) begin
                m_in_hold = 1'b1;
                m_elapsed = 0;
                m_cause   = press ? 1 : 2;
                m_count   = (m_count >= 255) ? 255 : m_count + 1;
            end else begin
                m_since_rel++;
            end
            m_s1 = m_s0;
            m_s0 = b;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        bit e_cpu;
        e_cpu = !m_in_hold && (m_since_rel >= CD);
        chk("periph_rst_n", 8'(periph_rst_n), 8'(!m_in_hold));
        chk("cpu_rst_n",    8'(cpu_rst_n),    8'(e_cpu));
        chk("seq_busy",     8'(seq_busy),     8'(!e_cpu));
        chk("rst_cause",    8'(rst_cause),    8'(m_cause));
        chk("rst_count",    rst_count,        8'(m_count));
    endtask

    task automatic tick(input bit b, input bit w, input bit r);
        btn_n      = b;
        wdt_expire = w;
        resetn     = r;
        @(posedge clock);
        model_step(b, w, r);
        #1;
        check_model();
    endtask

    // Idle until the CPU is released, bounded.
    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (cpu_rst_n !== 1'b1 && n < 200) begin
            tick(1'b1, 1'b0, 1'b1);
            n++;
        end
        chk(tag, 8'(cpu_rst_n), 8'd1);
    endtask

    // Idle until peripherals are released, bounded.
    task automatic wait_periph(input string tag);
        int n;
        n = 0;
        while (periph_rst_n !== 1'b1 && n < 200) begin
            tick(1'b1, 1'b0, 1'b1);
            n++;
        end
        chk(tag, 8'(periph_rst_n), 8'd1);
    endtask

    initial begin
        int n;
        int cnt0;
        int seg_len;
        bit seg_val;

        // power-on reset, 3 cycles
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        chk("reset_busy",  8'(seq_busy),  8'd1);
        chk("reset_cause", 8'(rst_cause), 8'd0);

        // release timing: peripherals after 8 cycles, CPU 4 later
        n = 0;
        while (periph_rst_n !== 1'b1 && n < 50) begin
            tick(1'b1, 1'b0, 1'b1);
            n++;
        end
        chk("por_periph_delay", 8'(n), 8'(PH));
        n = 0;
        while (cpu_rst_n !== 1'b1 && n < 50) begin
            tick(1'b1, 1'b0, 1'b1);
            n++;
        end
        chk("por_cpu_delay", 8'(n), 8'(CD));
        chk("por_busy", 8'(seq_busy), 8'd0);

        // watchdog pulse in RUN
        tick(1'b1, 1'b1, 1'b1);
        chk("wdt_periph", 8'(periph_rst_n), 8'd0);
        chk("wdt_cpu",    8'(cpu_rst_n),    8'd0);
        chk("wdt_cause",  8'(rst_cause),    8'd2);
        chk("wdt_count",  rst_count,        8'd1);
        wait_run("wdt_release");

`ifdef RST_DEBOUNCE_EN
        // short press is filtered out
        cnt0 = int'(rst_count);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        chk("short_press_cpu",   8'(cpu_rst_n), 8'd1);
        chk("short_press_count", rst_count,     8'(cnt0));
        // long press: one reset, hold until released
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b1);
        chk("long_press_hold", 8'(periph_rst_n), 8'd0);
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b0, 1'b1);
        chk("long_press_cause", 8'(rst_cause), 8'd1);
        chk("long_press_count", rst_count,     8'(cnt0 + 1));
`else
        // button press and watchdog on the same cycle during PERIPH
        tick(1'b1, 1'b1, 1'b1);
        wait_periph("coincide_enter_periph");
        cnt0 = int'(rst_count);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("coincide_cause",  8'(rst_cause),    8'd1);
        chk("coincide_count",  rst_count,        8'(cnt0 + 1));
        chk("coincide_periph", 8'(periph_rst_n), 8'd0);
`endif
        wait_run("after_button");

        // random phase
        seg_len = 0;
        seg_val = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (seg_len == 0) begin
                seg_val = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
                seg_len = seg_val ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
            end
            seg_len--;
            tick(seg_val, ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) != 0));
        end
        wait_run("after_random");

        // resetn during PERIPH aborts everything, including the count
        tick(1'b1, 1'b1, 1'b1);
        wait_periph("abort_enter_periph");
        tick(1'b1, 1'b0, 1'b0);
        chk("abort_periph", 8'(periph_rst_n), 8'd0);
        chk("abort_cpu",    8'(cpu_rst_n),    8'd0);
        chk("abort_busy",   8'(seq_busy),     8'd1);
        chk("abort_cause",  8'(rst_cause),    8'd0);
        chk("abort_count",  rst_count,        8'd0);

        // count saturation over 300 watchdog events
        wait_run("sat_start");
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b1, 1'b1);
            wait_run("sat_release");
        end
        chk("sat_count", rst_count, 8'd255);
        chk("sat_cause", 8'(rst_cause), 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
